div_unit: RTL



---
 rtl/div_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: sequential signed divider (restoring, one quotient bit per cycle).
// Quotient is returned on lo and remainder on hi, with MIPS DIV semantics:
// the quotient truncates toward zero and the remainder takes the dividend's sign.
// A zero divisor skips the iteration, raises div_zero and leaves lo/hi untouched.
// Optional build macro DIV_EARLY_OUT_EN: when |a| < |b| the answer (lo=0, hi=a)
// is known at capture time, so the unit jumps straight to DONE. The results are
// the same in both builds; only the latency changes.

module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             fim,
   output logic             div_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t next_state;

   // Magnitude working registers plus the signs needed to restore the result.
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] abs_b;
   logic [CNT_W-1:0] count;
   logic             sign_q;
   logic             sign_r;
   logic             div_zero_pending;

   // Combinational helpers for operand capture and the restoring step.
   logic [WIDTH-1:0] abs_a_in;
   logic [WIDTH-1:0] abs_b_in;
   logic             b_is_zero;
   logic             early_out;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_sub;
   logic             rem_ge;
   logic             last_step;

   // Operand magnitudes and the shortcut decisions taken in IDLE.
   always_comb begin
      abs_a_in  = a[WIDTH-1] ? -a : a;
      abs_b_in  = b[WIDTH-1] ? -b : b;
      b_is_zero = (b == '0);
`ifdef DIV_EARLY_OUT_EN
      early_out = !b_is_zero && (abs_a_in < abs_b_in);
`else
      early_out = 1'b0;
`endif
   end

   // One restoring step: the remainder is shifted into a WIDTH+1-bit value so
   // the compare against |b| can never overflow, even for |b| = 2^(WIDTH-1).
   always_comb begin
      rem_shift = {rem, q[WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, abs_b});
      rem_sub   = rem_shift[WIDTH-1:0] - abs_b;
      last_step = (count == CNT_W'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and busy flag.
   always_comb begin
      next_state = state;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               if (b_is_zero || early_out) begin
                  next_state = DONE;
               end else begin
                  next_state = RUN;
               end
            end
         end
         RUN: begin
            if (last_step) begin
               next_state = FIX;
            end
         end
         FIX: begin
            next_state = DONE;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand capture in IDLE and the iterative quotient/remainder update in RUN.
   always_ff @(posedge clock) begin
      if (reset) begin
         q                <= '0;
         rem              <= '0;
         abs_b            <= '0;
         count            <= '0;
         sign_q           <= 1'b0;
         sign_r           <= 1'b0;
         div_zero_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sign_q           <= a[WIDTH-1] ^ b[WIDTH-1];
                  sign_r           <= a[WIDTH-1];
                  q                <= abs_a_in;
                  rem              <= '0;
                  abs_b            <= abs_b_in;
                  count            <= '0;
                  div_zero_pending <= b_is_zero;
               end
            end
            RUN: begin
               rem   <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
               q     <= {q[WIDTH-2:0], rem_ge};
               count <= count + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Architectural results: sign fix-up, completion pulse and zero flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         lo       <= '0;
         hi       <= '0;
         fim      <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         fim <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  div_zero <= 1'b0;
                  if (early_out) begin
                     lo <= '0;
                     hi <= a;
                  end
               end
            end
            FIX: begin
               lo <= sign_q ? -q : q;
               hi <= sign_r ? -rem : rem;
            end
            DONE: begin
               fim      <= 1'b1;
               div_zero <= div_zero_pending;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
